decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Upstream neighbour of the 8-entry x 8-bit register file.
- Accepts one 9-bit instruction per cycle from fetch and decodes it.
- Drives the register file's readRegister1/readRegister2/immediate/ltValue/regWrite inputs, plus ALU/branch controls, from a one-deep pipeline register.
- A start/halt FSM gates instruction acceptance and reports program completion.

Parameters:
- IW, 9, instruction width.
- RW, 3, register index width (8 registers).
- DW, 8, data width of ltValue.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle pulse; begins execution from IDLE or DONE
- instrValid  input  1  fetch has a valid instruction
- instruction  input  IW  [8:6] opcode, [5:3] ra, [2:0] rb/lut index/sub-op
- stall  input  1  downstream cannot accept; freeze outputs
- instrReady  output  1  decode will accept instruction this cycle
- readRegister1  output  RW  ra field (also the write destination)
- readRegister2  output  RW  rb field
- immediate  output  1  select ltValue as second operand
- ltValue  output  DW  immediate from lookup table
- regWrite  output  1  write back to readRegister1
- aluOp  output  3  ALU operation (isa_pkg enum)
- branch  output  1  BNE decoded
- decValid  output  1  decoded outputs are valid this cycle
- done  output  1  HALT retired; sticky

Behaviour:
- Reset (async, any time, including mid-program): state=IDLE; every output 0; LUT index register 0.
- FSM states and transitions:
  - IDLE: start -> RUN.
  - RUN: HALT accepted -> DONE.
  - DONE: start -> RUN; done clears on the same edge.
  - start while in RUN: ignored.
- instrReady = (state==RUN) && !stall. Combinational; no dependence on instrValid.
- Accept = instrValid && instrReady. On accept:
  - All decoded fields register on that edge.
  - decValid=1 the next cycle (latency 1).
- RUN, no accept, stall=0: decValid=0 and regWrite=0 (bubble); other fields hold their last values.
- stall=1: all outputs hold, including decValid and regWrite. No new instruction is accepted.
- Decode table (opcode):
  - 000 ADD, 001 SUB, 010 AND, 011 XOR: immediate=0, regWrite=1.
  - 100 LDI: immediate=1, regWrite=1, aluOp=PASSB.
  - 101 ADDI: immediate=1, regWrite=1, aluOp=ADD.
  - 110 BNE: regWrite=0, branch=1, immediate=0, aluOp=SUB.
  - 111 SPECIAL: rb=000 HALT, anything else NOP. Both: regWrite=0, branch=0.
- HALT on accept:
  - Next cycle: decValid=1, regWrite=0, state=DONE, done=1.
  - done stays 1 until start or reset.
- Instructions presented while in DONE or IDLE are not accepted (instrReady=0).
- regWrite and branch are never 1 unless decValid=1.
- ltValue = LUT[rb] when immediate=1, else 0. LUT contents: 0x00, 0x01, 0x02, 0x04, 0x08, 0x10, 0x7F, 0xFF. ltValue is fully registered.
- readRegister1/readRegister2 always carry the ra/rb fields, including for immediate ops.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared package isa_pkg holds:
  - opcode_t enum (ADD..SPECIAL).
  - alu_op_t enum (ADD, SUB, AND, XOR, PASSB).
  - SUB_HALT constant.
  - LUT contents as a localparam array.
- One sub-module, imm_lut: combinational 3-bit index -> 8-bit value, shared later with the branch-target LUT pattern.
- FSM and pipeline register stay in decode_stage.

Test Plan:
- Reset mid-RUN with decValid=1 -> next sample: all outputs 0, instrReady=0. start then instruction 9'b000_001_010 -> next cycle: decValid=1, readRegister1=1, readRegister2=2, regWrite=1, aluOp=ADD.
- RUN, instruction 9'b100_011_110 (LDI r3, idx 6) -> immediate=1, ltValue=0x7F, regWrite=1. Then 9'b101_000_111 -> ltValue=0xFF, aluOp=ADD.
- Accept ADD, then hold stall=1 for 3 cycles with a new instrValid -> outputs frozen, instrReady=0 throughout. Release -> new instruction decoded one cycle later.
- instrValid=0 for 2 cycles in RUN -> decValid=0, regWrite=0; readRegister1 unchanged.
- 9'b111_000_000 (HALT) -> decValid=1, regWrite=0, done=1, instrReady=0 thereafter. Later start -> done=0, RUN, next instruction accepted.
- 9'b111_000_101 (reserved) -> NOP: decValid=1, regWrite=0, branch=0, state stays RUN. 9'b110_010_011 -> branch=1, regWrite=0.

Source files
------------

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA definitions for the decode stage
//
// Purpose : opcode and ALU operation encodings, SPECIAL sub-op constants,
//           field widths and the immediate lookup table contents.
// Ports   : none (package).
package isa_pkg;

    localparam int IW = 9;
    localparam int RW = 3;
    localparam int DW = 8;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_AND     = 3'b010,
        OP_XOR     = 3'b011,
        OP_LDI     = 3'b100,
        OP_ADDI    = 3'b101,
        OP_BNE     = 3'b110,
        OP_SPECIAL = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_XOR   = 3'd3,
        ALU_PASSB = 3'd4
    } alu_op_t;

    // SPECIAL opcode: rb field selects the sub-operation; only HALT is defined.
    localparam logic [RW-1:0] SUB_HALT = 3'b000;

    localparam logic [DW-1:0] IMM_LUT [8] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h7F, 8'hFF
    };

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/downstream bus of the decode stage
//
// Purpose : groups the fetch handshake, start/stall controls and decoded
//           outputs driven toward the register file / ALU.
// Ports   : master - fetch/control side (drives start, instrValid,
//                    instruction, stall; observes everything else)
//           slave  - decode_stage side
interface decode_stage_if;
    import isa_pkg::*;

    logic          start;
    logic          instrValid;
    logic [IW-1:0] instruction;
    logic          stall;
    logic          instrReady;
    logic [RW-1:0] readRegister1;
    logic [RW-1:0] readRegister2;
    logic          immediate;
    logic [DW-1:0] ltValue;
    logic          regWrite;
    alu_op_t       aluOp;
    logic          branch;
    logic          decValid;
    logic          done;

    modport master (
        output start, instrValid, instruction, stall,
        input  instrReady, readRegister1, readRegister2, immediate, ltValue,
               regWrite, aluOp, branch, decValid, done
    );

    modport slave (
        input  start, instrValid, instruction, stall,
        output instrReady, readRegister1, readRegister2, immediate, ltValue,
               regWrite, aluOp, branch, decValid, done
    );

endinterface

// File: rtl/decode_stage_imm_lut.sv
// rtl/decode_stage_imm_lut.sv - combinational immediate lookup table
//
// Purpose : maps a 3-bit index onto the fixed 8-bit immediate table.
// Ports   : idx_i   - table index
//           value_o - table entry
module imm_lut
    import isa_pkg::*;
(
    input  logic [RW-1:0] idx_i,
    output logic [DW-1:0] value_o
);

    assign value_o = IMM_LUT[idx_i];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with start/halt control
//
// Purpose : accepts one instruction per cycle while running, decodes it into
//           register file / ALU / branch controls held in a one-deep output
//           register, and reports program completion on HALT.
// Ports   : clock - rising-edge clock
//           reset - asynchronous active-high, clears all state
//           bus   - decode_stage_if slave: start, fetch handshake, stall,
//                   decoded outputs, done
module decode_stage
    import isa_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    decode_stage_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rr1_q, rr1_d;
    logic [RW-1:0] rr2_q, rr2_d;
    logic          imm_q, imm_d;
    logic [DW-1:0] lt_q, lt_d;
    logic          rw_q, rw_d;
    alu_op_t       alu_q, alu_d;
    logic          br_q, br_d;
    logic          dv_q, dv_d;
    logic          done_q, done_d;

    logic          ready;
    logic          accept;
    opcode_t       opcode;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic [DW-1:0] lut_value;

    assign opcode = opcode_t'(bus.instruction[8:6]);
    assign ra     = bus.instruction[5:3];
    assign rb     = bus.instruction[2:0];

    // Readiness depends only on state and stall so fetch can use it as a
    // pure backpressure signal.
    assign ready  = (state_q == ST_RUN) && !bus.stall;
    assign accept = bus.instrValid && ready;

    imm_lut u_imm_lut (
        .idx_i   (rb),
        .value_o (lut_value)
    );

    always_comb begin
        state_d = state_q;
        rr1_d   = rr1_q;
        rr2_d   = rr2_q;
        imm_d   = imm_q;
        lt_d    = lt_q;
        rw_d    = rw_q;
        alu_d   = alu_q;
        br_d    = br_q;
        dv_d    = dv_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (accept && opcode == OP_SPECIAL && rb == SUB_HALT) begin
                         state_d = ST_DONE;
                         done_d  = 1'b1;
                     end
            ST_DONE: if (bus.start) begin
                         state_d = ST_RUN;
                         done_d  = 1'b0;
                     end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            rr1_d = ra;
            rr2_d = rb;
            dv_d  = 1'b1;
            imm_d = 1'b0;
            rw_d  = 1'b0;
            br_d  = 1'b0;
            alu_d = ALU_ADD;
            case (opcode)
                OP_ADD:  begin alu_d = ALU_ADD;   rw_d = 1'b1; end
                OP_SUB:  begin alu_d = ALU_SUB;   rw_d = 1'b1; end
                OP_AND:  begin alu_d = ALU_AND;   rw_d = 1'b1; end
                OP_XOR:  begin alu_d = ALU_XOR;   rw_d = 1'b1; end
                OP_LDI:  begin alu_d = ALU_PASSB; rw_d = 1'b1; imm_d = 1'b1; end
                OP_ADDI: begin alu_d = ALU_ADD;   rw_d = 1'b1; imm_d = 1'b1; end
                OP_BNE:  begin alu_d = ALU_SUB;   br_d = 1'b1; end
                default: ; // SPECIAL: HALT and NOP write nothing
            endcase
            lt_d = imm_d ? lut_value : '0;
        end else if (!bus.stall) begin
            // Bubble: kill the side-effecting controls, keep the data fields.
            dv_d = 1'b0;
            rw_d = 1'b0;
            br_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr1_q   <= '0;
            rr2_q   <= '0;
            imm_q   <= 1'b0;
            lt_q    <= '0;
            rw_q    <= 1'b0;
            alu_q   <= ALU_ADD;
            br_q    <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr1_q   <= rr1_d;
            rr2_q   <= rr2_d;
            imm_q   <= imm_d;
            lt_q    <= lt_d;
            rw_q    <= rw_d;
            alu_q   <= alu_d;
            br_q    <= br_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
        end
    end

    assign bus.instrReady    = ready;
    assign bus.readRegister1 = rr1_q;
    assign bus.readRegister2 = rr2_q;
    assign bus.immediate     = imm_q;
    assign bus.ltValue       = lt_q;
    assign bus.regWrite      = rw_q;
    assign bus.aluOp         = alu_q;
    assign bus.branch        = br_q;
    assign bus.decValid      = dv_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    import isa_pkg::*;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    decode_stage_if bus ();

    decode_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [8:0] ins);
        bus.instrValid  = 1'b1;
        bus.instruction = ins;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".decValid"},  32'(bus.decValid), 0);
        check({tag, ".regWrite"},  32'(bus.regWrite), 0);
        check({tag, ".branch"},    32'(bus.branch), 0);
        check({tag, ".immediate"}, 32'(bus.immediate), 0);
        check({tag, ".ltValue"},   32'(bus.ltValue), 0);
        check({tag, ".rr1"},       32'(bus.readRegister1), 0);
        check({tag, ".rr2"},       32'(bus.readRegister2), 0);
        check({tag, ".aluOp"},     32'(bus.aluOp), 0);
        check({tag, ".done"},      32'(bus.done), 0);
        check({tag, ".ready"},     32'(bus.instrReady), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start       = 1'b0;
        bus.instrValid  = 1'b0;
        bus.instruction = '0;
        bus.stall       = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check_all_zero("por");

        // start from IDLE
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("run.ready", 32'(bus.instrReady), 1);

        // reset mid-RUN while decValid=1
        present(9'b000_001_010);
        step();
        check("pre_rst.decValid", 32'(bus.decValid), 1);
        reset = 1'b1;
        #1;
        check_all_zero("mid_rst");
        step();
        reset = 1'b0;
        bus.instrValid = 1'b0;
        step();
        check("idle.ready", 32'(bus.instrReady), 0);

        // restart, ADD r1,r2
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        present(9'b000_001_010);
        step();
        check("add.decValid", 32'(bus.decValid), 1);
        check("add.rr1",      32'(bus.readRegister1), 1);
        check("add.rr2",      32'(bus.readRegister2), 2);
        check("add.regWrite", 32'(bus.regWrite), 1);
        check("add.aluOp",    32'(bus.aluOp), 32'(ALU_ADD));
        check("add.imm",      32'(bus.immediate), 0);
        check("add.lt",       32'(bus.ltValue), 0);

        // LDI r3, idx 6
        present(9'b100_011_110);
        step();
        check("ldi.imm",      32'(bus.immediate), 1);
        check("ldi.lt",       32'(bus.ltValue), 32'h7F);
        check("ldi.regWrite", 32'(bus.regWrite), 1);
        check("ldi.aluOp",    32'(bus.aluOp), 32'(ALU_PASSB));
        check("ldi.rr1",      32'(bus.readRegister1), 3);
        check("ldi.rr2",      32'(bus.readRegister2), 6);

        // ADDI r0, idx 7
        present(9'b101_000_111);
        step();
        check("addi.lt",    32'(bus.ltValue), 32'hFF);
        check("addi.aluOp", 32'(bus.aluOp), 32'(ALU_ADD));
        check("addi.imm",   32'(bus.immediate), 1);

        // ADD r2,r1 then stall three cycles with SUB r4,r5 pending
        present(9'b000_010_001);
        step();
        check("pre_stall.rr1", 32'(bus.readRegister1), 2);
        bus.stall = 1'b1;
        present(9'b001_100_101);
        #1;
        check("stall.ready0", 32'(bus.instrReady), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.decValid", 32'(bus.decValid), 1);
            check("stall.regWrite", 32'(bus.regWrite), 1);
            check("stall.rr1",      32'(bus.readRegister1), 2);
            check("stall.aluOp",    32'(bus.aluOp), 32'(ALU_ADD));
            check("stall.ready",    32'(bus.instrReady), 0);
        end
        bus.stall = 1'b0;
        #1;
        check("unstall.ready", 32'(bus.instrReady), 1);
        step();
        check("sub.decValid", 32'(bus.decValid), 1);
        check("sub.rr1",      32'(bus.readRegister1), 4);
        check("sub.rr2",      32'(bus.readRegister2), 5);
        check("sub.aluOp",    32'(bus.aluOp), 32'(ALU_SUB));

        // two bubble cycles
        bus.instrValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("bubble.decValid", 32'(bus.decValid), 0);
            check("bubble.regWrite", 32'(bus.regWrite), 0);
            check("bubble.rr1",      32'(bus.readRegister1), 4);
        end

        // start while in RUN is ignored
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("run_start.ready", 32'(bus.instrReady), 1);
        check("run_start.done",  32'(bus.done), 0);

        // reserved SPECIAL -> NOP
        present(9'b111_000_101);
        step();
        check("nop.decValid", 32'(bus.decValid), 1);
        check("nop.regWrite", 32'(bus.regWrite), 0);
        check("nop.branch",   32'(bus.branch), 0);
        check("nop.ready",    32'(bus.instrReady), 1);
        check("nop.done",     32'(bus.done), 0);

        // BNE r2,r3
        present(9'b110_010_011);
        step();
        check("bne.branch",   32'(bus.branch), 1);
        check("bne.regWrite", 32'(bus.regWrite), 0);
        check("bne.aluOp",    32'(bus.aluOp), 32'(ALU_SUB));
        check("bne.imm",      32'(bus.immediate), 0);
        check("bne.rr1",      32'(bus.readRegister1), 2);
        check("bne.rr2",      32'(bus.readRegister2), 3);
        bus.instrValid = 1'b0;
        step();
        check("bne_bub.branch", 32'(bus.branch), 0);

        // HALT
        present(9'b111_000_000);
        step();
        check("halt.decValid", 32'(bus.decValid), 1);
        check("halt.regWrite", 32'(bus.regWrite), 0);
        check("halt.done",     32'(bus.done), 1);
        check("halt.ready",    32'(bus.instrReady), 0);
        present(9'b000_110_110);
        step();
        check("done.decValid", 32'(bus.decValid), 0);
        check("done.done",     32'(bus.done), 1);
        check("done.ready",    32'(bus.instrReady), 0);
        check("done.rr1",      32'(bus.readRegister1), 0);

        // restart from DONE
        bus.instrValid = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart.done",  32'(bus.done), 0);
        check("restart.ready", 32'(bus.instrReady), 1);
        present(9'b011_111_000);
        step();
        check("xor.decValid", 32'(bus.decValid), 1);
        check("xor.aluOp",    32'(bus.aluOp), 32'(ALU_XOR));
        check("xor.rr1",      32'(bus.readRegister1), 7);
        check("xor.regWrite", 32'(bus.regWrite), 1);

        // simultaneous start and reset: reset wins
        bus.instrValid = 1'b0;
        reset = 1'b1;
        bus.start = 1'b1;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        step();
        check("rst_start.ready",    32'(bus.instrReady), 0);
        check("rst_start.decValid", 32'(bus.decValid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
